// File: rtl/ascon_permutation_engine.sv
// Iterative Ascon permutation p^a (a = 6, 8 or 12) applying UNROLL rounds per clock.
// Optional build macro ASCON_PERM_INPUT_XOR_EN adds xor_i, folded into x0 when a job is accepted.

package ascon_pack;
    typedef struct packed {
        logic [63:0] x0;
        logic [63:0] x1;
        logic [63:0] x2;
        logic [63:0] x3;
        logic [63:0] x4;
    } type_state;
endpackage

// Round constant {F - r, r} injected into the low byte of x2.
module constant_addition (
    input  ascon_pack::type_state state_i,
    input  logic [3:0]            round_i,
    output ascon_pack::type_state state_o
);
    logic [7:0] rc;

    always_comb begin
        rc         = {4'hF - round_i, round_i};
        state_o    = state_i;
        state_o.x2 = state_i.x2 ^ {56'd0, rc};
    end
endmodule

// 5-bit S-box applied to each of the 64 bit-columns; x0 is the column MSB.
module substitution_layer (
    input  ascon_pack::type_state state_i,
    output ascon_pack::type_state state_o
);
    localparam logic [4:0] SBOX [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };

    always_comb begin
        state_o = '0;
        for (int i = 0; i < 64; i++) begin
            {state_o.x0[i], state_o.x1[i], state_o.x2[i], state_o.x3[i], state_o.x4[i]} =
                SBOX[{state_i.x0[i], state_i.x1[i], state_i.x2[i], state_i.x3[i], state_i.x4[i]}];
        end
    end
endmodule

// Per-word linear mixing: x ^= ror(x, a) ^ ror(x, b).
module diffusion_layer (
    input  ascon_pack::type_state state_i,
    output ascon_pack::type_state state_o
);
    logic [63:0] x0, x1, x2, x3, x4;

    always_comb begin
        x0 = state_i.x0;
        x1 = state_i.x1;
        x2 = state_i.x2;
        x3 = state_i.x3;
        x4 = state_i.x4;
        state_o.x0 = x0 ^ {x0[18:0], x0[63:19]} ^ {x0[27:0], x0[63:28]};
        state_o.x1 = x1 ^ {x1[60:0], x1[63:61]} ^ {x1[38:0], x1[63:39]};
        state_o.x2 = x2 ^ {x2[0],    x2[63:1]}  ^ {x2[5:0],  x2[63:6]};
        state_o.x3 = x3 ^ {x3[9:0],  x3[63:10]} ^ {x3[16:0], x3[63:17]};
        state_o.x4 = x4 ^ {x4[6:0],  x4[63:7]}  ^ {x4[40:0], x4[63:41]};
    end
endmodule

// One full Ascon round.
module ascon_round (
    input  ascon_pack::type_state state_i,
    input  logic [3:0]            round_i,
    output ascon_pack::type_state state_o
);
    ascon_pack::type_state after_c;
    ascon_pack::type_state after_s;

    constant_addition  u_const (.state_i(state_i), .round_i(round_i), .state_o(after_c));
    substitution_layer u_subst (.state_i(after_c), .state_o(after_s));
    diffusion_layer    u_diff  (.state_i(after_s), .state_o(state_o));
endmodule

module ascon_permutation_engine #(
    parameter int unsigned UNROLL = 1
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  start_i,
    input  logic [3:0]            nrounds_i,
    input  ascon_pack::type_state state_i,
`ifdef ASCON_PERM_INPUT_XOR_EN
    input  logic [63:0]           xor_i,
`endif
    output logic                  ready_o,
    output ascon_pack::type_state state_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  err_o
);
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] STEP = CNT_W'(UNROLL);

    if (UNROLL != 1 && UNROLL != 2) begin : g_bad_unroll
        $fatal(1, "ascon_permutation_engine: UNROLL must be 1 or 2");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

    fsm_t                  fsm_q, fsm_n;
    ascon_pack::type_state reg_q, reg_n;
    logic [CNT_W-1:0]      cnt_q, cnt_n;
    logic [CNT_W-1:0]      nr_q, nr_n;
    logic                  err_q, err_n;

    logic                  use_input;
    logic                  legal;
    logic                  accept;
    logic [CNT_W-1:0]      base_round;
    ascon_pack::type_state src;
    ascon_pack::type_state stage [UNROLL+1];

    // Outside RUN the rounds always work on the incoming job, so an accept needs no extra cycle.
    always_comb begin : datapath_sel
        use_input = (fsm_q != RUN);
        src       = state_i;
`ifdef ASCON_PERM_INPUT_XOR_EN
        src.x0    = state_i.x0 ^ xor_i;
`endif
        if (!use_input) begin
            src = reg_q;
        end
        base_round = use_input ? CNT_W'(4'd12 - nrounds_i)
                               : CNT_W'(4'd12 - nr_q + cnt_q);
    end

    assign stage[0] = src;

    for (genvar j = 0; j < UNROLL; j++) begin : g_round
        ascon_round u_round (
            .state_i (stage[j]),
            .round_i (CNT_W'(base_round + CNT_W'(j))),
            .state_o (stage[j+1])
        );
    end

    assign legal = (nrounds_i == 4'd6 || nrounds_i == 4'd8 || nrounds_i == 4'd12)
                 && (UNROLL == 1 || nrounds_i[0] == 1'b0);

    // Next-state and handshake; DONE re-accepts in the same cycle the result is taken.
    always_comb begin : fsm_next
        fsm_n   = fsm_q;
        reg_n   = reg_q;
        cnt_n   = cnt_q;
        nr_n    = nr_q;
        err_n   = 1'b0;
        ready_o = 1'b0;
        accept  = 1'b0;

        case (fsm_q)
            IDLE:    ready_o = 1'b1;
            DONE:    ready_o = ready_i;
            default: ready_o = 1'b0;
        endcase

        accept = start_i && ready_o && legal;
        err_n  = start_i && ready_o && !legal;

        if (fsm_q == RUN) begin
            reg_n = stage[UNROLL];
            cnt_n = cnt_q + STEP;
            if (cnt_n == nr_q) begin
                fsm_n = DONE;
            end
        end else if (accept) begin
            reg_n = stage[UNROLL];
            cnt_n = STEP;
            nr_n  = nrounds_i;
            fsm_n = (nrounds_i == STEP) ? DONE : RUN;
        end else if (fsm_q == DONE && ready_i) begin
            fsm_n = IDLE;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            fsm_q <= IDLE;
            reg_q <= '0;
            cnt_q <= '0;
            nr_q  <= '0;
            err_q <= 1'b0;
        end else begin
            fsm_q <= fsm_n;
            reg_q <= reg_n;
            cnt_q <= cnt_n;
            nr_q  <= nr_n;
            err_q <= err_n;
        end
    end

    assign state_o = reg_q;
    assign valid_o = (fsm_q == DONE);
    assign err_o   = err_q;

endmodule

// File: tb/tb_ascon_permutation_engine.sv
// Directed bench for ascon_permutation_engine: UNROLL=1 and UNROLL=2 instances against a
// word-level reference permutation written in the style of the Ascon C reference.
module tb_ascon_permutation_engine;
    typedef ascon_pack::type_state st_t;

    logic clk;
    logic rst;

    logic       st1, rdy1, ro1, vo1, eo1;
    logic [3:0] nr1;
    st_t        si1, so1;
    logic       st2, rdy2, ro2, vo2, eo2;
    logic [3:0] nr2;
    st_t        si2, so2;
`ifdef ASCON_PERM_INPUT_XOR_EN
    logic [63:0] xor1, xor2;
`endif

    int checks = 0;
    int passes = 0;

    ascon_permutation_engine #(.UNROLL(1)) u_dut1 (
        .clock_i(clk), .reset_i(rst), .start_i(st1), .nrounds_i(nr1), .state_i(si1),
`ifdef ASCON_PERM_INPUT_XOR_EN
        .xor_i(xor1),
`endif
        .ready_o(ro1), .state_o(so1), .valid_o(vo1), .ready_i(rdy1), .err_o(eo1)
    );

    ascon_permutation_engine #(.UNROLL(2)) u_dut2 (
        .clock_i(clk), .reset_i(rst), .start_i(st2), .nrounds_i(nr2), .state_i(si2),
`ifdef ASCON_PERM_INPUT_XOR_EN
        .xor_i(xor2),
`endif
        .ready_o(ro2), .state_o(so2), .valid_o(vo2), .ready_i(rdy2), .err_o(eo2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic st_t ref_perm(input st_t s, input int a);
        logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
        st_t o;
        x0 = s.x0; x1 = s.x1; x2 = s.x2; x3 = s.x3; x4 = s.x4;
        for (int r = 12 - a; r < 12; r++) begin
            x2 = x2 ^ 64'(((15 - r) << 4) | r);
            x0 ^= x4; x4 ^= x3; x2 ^= x1;
            t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
            x0 ^= t1; x1 ^= t2; x2 ^= t3; x3 ^= t4; x4 ^= t0;
            x1 ^= x0; x0 ^= x4; x3 ^= x2; x2 = ~x2;
            x0 ^= rotr(x0, 19) ^ rotr(x0, 28);
            x1 ^= rotr(x1, 61) ^ rotr(x1, 39);
            x2 ^= rotr(x2, 1)  ^ rotr(x2, 6);
            x3 ^= rotr(x3, 10) ^ rotr(x3, 17);
            x4 ^= rotr(x4, 7)  ^ rotr(x4, 41);
        end
        o.x0 = x0; o.x1 = x1; o.x2 = x2; o.x3 = x3; o.x4 = x4;
        return o;
    endfunction

    function automatic logic valid_of(input int u);
        return (u == 1) ? vo1 : vo2;
    endfunction

    // Offer a job to an idle unit; returns at the first falling edge after the accept edge.
    task automatic issue(input int u, input logic [3:0] nr, input st_t s);
        @(negedge clk);
        if (u == 1) begin st1 = 1'b1; nr1 = nr; si1 = s; end
        else        begin st2 = 1'b1; nr2 = nr; si2 = s; end
        @(negedge clk);
        st1 = 1'b0;
        st2 = 1'b0;
    endtask

    // Edges from accept until valid_o is seen; -1 when the budget runs out.
    task automatic wait_valid(input int u, input int budget, output int lat);
        lat = 1;
        while (!valid_of(u) && lat < budget) begin
            @(negedge clk);
            lat++;
        end
        if (!valid_of(u)) lat = -1;
    endtask

    task automatic release_result(input int u);
        @(negedge clk);
        if (u == 1) rdy1 = 1'b1; else rdy2 = 1'b1;
        @(negedge clk);
        rdy1 = 1'b0;
        rdy2 = 1'b0;
    endtask

    st_t init_s, mix_s;

    task automatic test_reset;
        rst = 1'b1;
        st1 = 1'b0; rdy1 = 1'b0; nr1 = 4'd0; si1 = '0;
        st2 = 1'b0; rdy2 = 1'b0; nr2 = 4'd0; si2 = '0;
`ifdef ASCON_PERM_INPUT_XOR_EN
        xor1 = '0; xor2 = '0;
`endif
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checks++; if (ro1 !== 1'b1) $display("FAIL reset_ready1: got %b want 1", ro1); else passes++;
        checks++; if (vo1 !== 1'b0) $display("FAIL reset_valid1: got %b want 0", vo1); else passes++;
        checks++; if (eo1 !== 1'b0) $display("FAIL reset_err1: got %b want 0", eo1); else passes++;
        checks++; if (so1 !== st_t'('0)) $display("FAIL reset_state1: got %h want 0", so1); else passes++;
        checks++; if (ro2 !== 1'b1) $display("FAIL reset_ready2: got %b want 1", ro2); else passes++;
        checks++; if (vo2 !== 1'b0) $display("FAIL reset_valid2: got %b want 0", vo2); else passes++;
        checks++; if (so2 !== st_t'('0)) $display("FAIL reset_state2: got %h want 0", so2); else passes++;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (ro1 !== 1'b1 || vo1 !== 1'b0 || eo1 !== 1'b0 || so1 !== st_t'('0))
                $display("FAIL idle_hold cycle %0d: got ready=%b valid=%b err=%b want 1/0/0", c, ro1, vo1, eo1);
            else passes++;
        end
    endtask

    task automatic test_p12_unroll1;
        int  lat;
        st_t exp;
        exp = ref_perm(init_s, 12);
        issue(1, 4'd12, init_s);
        checks++; if (ro1 !== 1'b0) $display("FAIL p12_busy_ready: got %b want 0", ro1); else passes++;
        wait_valid(1, 40, lat);
        checks++; if (lat != 12) $display("FAIL p12_latency: got %0d want 12", lat); else passes++;
        checks++; if (so1 !== exp) $display("FAIL p12_state: got %h want %h", so1, exp); else passes++;
    endtask

    // Result held under back-pressure, then taken together with a new start.
    task automatic test_back_to_back;
        int  lat;
        st_t exp1, exp2;
        exp1 = ref_perm(init_s, 12);
        exp2 = ref_perm(exp1, 12);
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            checks++;
            if (vo1 !== 1'b1 || so1 !== exp1)
                $display("FAIL hold cycle %0d: got valid=%b state=%h want 1 %h", c, vo1, so1, exp1);
            else passes++;
        end
        @(negedge clk);
        rdy1 = 1'b1; st1 = 1'b1; nr1 = 4'd12; si1 = exp1;
        #1;
        checks++; if (ro1 !== 1'b1) $display("FAIL b2b_ready: got %b want 1", ro1); else passes++;
        @(negedge clk);
        rdy1 = 1'b0; st1 = 1'b0;
        wait_valid(1, 40, lat);
        checks++; if (lat != 12) $display("FAIL b2b_latency: got %0d want 12", lat); else passes++;
        checks++; if (so1 !== exp2) $display("FAIL b2b_state: got %h want %h", so1, exp2); else passes++;
        release_result(1);
        checks++; if (ro1 !== 1'b1 || vo1 !== 1'b0) $display("FAIL b2b_release: got ready=%b valid=%b want 1/0", ro1, vo1); else passes++;
    endtask

    task automatic test_unroll2;
        int  lat;
        st_t exp6, exp8, exp_b;
        exp6  = ref_perm(mix_s, 6);
        exp8  = ref_perm(mix_s, 8);
        exp_b = ref_perm(exp8, 6);
        issue(2, 4'd6, mix_s);
        wait_valid(2, 20, lat);
        checks++; if (lat != 3) $display("FAIL p6_u2_latency: got %0d want 3", lat); else passes++;
        checks++; if (so2 !== exp6) $display("FAIL p6_u2_state: got %h want %h", so2, exp6); else passes++;
        release_result(2);
        issue(2, 4'd8, mix_s);
        wait_valid(2, 20, lat);
        checks++; if (lat != 4) $display("FAIL p8_u2_latency: got %0d want 4", lat); else passes++;
        checks++; if (so2 !== exp8) $display("FAIL p8_u2_state: got %h want %h", so2, exp8); else passes++;
        @(negedge clk);
        rdy2 = 1'b1; st2 = 1'b1; nr2 = 4'd6; si2 = exp8;
        @(negedge clk);
        rdy2 = 1'b0; st2 = 1'b0;
        wait_valid(2, 20, lat);
        checks++; if (lat != 3) $display("FAIL b2b_u2_latency: got %0d want 3", lat); else passes++;
        checks++; if (so2 !== exp_b) $display("FAIL b2b_u2_state: got %h want %h", so2, exp_b); else passes++;
        release_result(2);
    endtask

    task automatic test_illegal;
        @(negedge clk);
        st1 = 1'b1; nr1 = 4'd7; si1 = mix_s;
        @(negedge clk);
        st1 = 1'b0;
        checks++; if (eo1 !== 1'b1) $display("FAIL illegal_err: got %b want 1", eo1); else passes++;
        checks++; if (ro1 !== 1'b1) $display("FAIL illegal_ready: got %b want 1", ro1); else passes++;
        @(negedge clk);
        checks++; if (eo1 !== 1'b0) $display("FAIL illegal_err_pulse: got %b want 0", eo1); else passes++;
        checks++; if (vo1 !== 1'b0 || ro1 !== 1'b1) $display("FAIL illegal_no_job: got valid=%b ready=%b want 0/1", vo1, ro1); else passes++;
        @(negedge clk);
        st2 = 1'b1; nr2 = 4'd0;
        @(negedge clk);
        st2 = 1'b0;
        checks++; if (eo2 !== 1'b1 || ro2 !== 1'b1) $display("FAIL illegal0_u2: got err=%b ready=%b want 1/1", eo2, ro2); else passes++;
    endtask

    task automatic test_reset_abort;
        bit seen;
        issue(1, 4'd12, init_s);
        @(negedge clk);
        st1 = 1'b1; nr1 = 4'd7;
        @(negedge clk);
        st1 = 1'b0;
        checks++; if (eo1 !== 1'b0) $display("FAIL busy_start_err: got %b want 0", eo1); else passes++;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (ro1 !== 1'b1 || vo1 !== 1'b0 || so1 !== st_t'('0))
            $display("FAIL abort_state: got ready=%b valid=%b state=%h want 1/0/0", ro1, vo1, so1);
        else passes++;
        seen = 1'b0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (vo1 === 1'b1) seen = 1'b1;
        end
        checks++; if (seen) $display("FAIL abort_no_valid: got valid rise want none"); else passes++;
    endtask

`ifdef ASCON_PERM_INPUT_XOR_EN
    task automatic test_input_xor;
        int  lat;
        st_t xs, exp;
        xs    = init_s;
        xs.x0 = xs.x0 ^ 64'h0123456789ABCDEF;
        exp   = ref_perm(xs, 12);
        xor1  = 64'h0123456789ABCDEF;
        issue(1, 4'd12, init_s);
        xor1  = '0;
        wait_valid(1, 40, lat);
        checks++; if (lat != 12) $display("FAIL xor_latency: got %0d want 12", lat); else passes++;
        checks++; if (so1 !== exp) $display("FAIL xor_state: got %h want %h", so1, exp); else passes++;
        release_result(1);
    endtask
`endif

    initial begin
        init_s = '{x0: 64'h80400c0600000000, x1: 64'h0, x2: 64'h0, x3: 64'h0, x4: 64'h0};
        mix_s  = '{x0: 64'h0123456789abcdef, x1: 64'hfedcba9876543210, x2: 64'h0,
                   x3: 64'hffffffffffffffff, x4: 64'h5555aaaa5555aaaa};
        test_reset;
        test_p12_unroll1;
        test_back_to_back;
        test_unroll2;
        test_illegal;
        test_reset_abort;
`ifdef ASCON_PERM_INPUT_XOR_EN
        test_input_xor;
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
